// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: read pointer, Gray export,
// write-pointer synchronizer and read-domain empty/level/underflow status.
module fifo_rd_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                       r_clk,
  input  logic                       r_rst,
  input  logic                       r_inc,
  input  logic [$clog2(DEPTH):0]     gray_w_ptr,
  output logic [$clog2(DEPTH)-1:0]   r_addr,
  output logic [$clog2(DEPTH):0]     gray_r_ptr,
  output logic                       r_empty,
  output logic                       r_almost_empty,
  output logic [$clog2(DEPTH):0]     r_level,
  output logic                       r_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_rd_ctrl: SYNC_STAGES must be at least 2");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("fifo_rd_ctrl: AE_THRESH must be below DEPTH");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_ptr_next;
  logic          pop;

  // Write-pointer synchronizer chain; the last stage is the only one used.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_w_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < int'(PW); i++) w_bin[i] = ^(wq >> i);
  end

  assign pop        = r_inc && !r_empty;
  assign r_ptr_next = r_ptr + PW'(pop);

  // Gray copy is built from the next pointer so it never lags r_ptr.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_ptr       <= '0;
      gray_r_ptr  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_ptr       <= r_ptr_next;
      gray_r_ptr  <= r_ptr_next ^ (r_ptr_next >> 1);
      r_underflow <= r_inc && r_empty;
    end
  end

  assign r_addr         = r_ptr[AW-1:0];
  assign r_empty        = (gray_r_ptr == wq);
  assign r_level        = w_bin - r_ptr;
  assign r_almost_empty = (r_level <= AE_LVL);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: integer-count reference model feeds an
// expectation queue that a negedge monitor drains and compares.
module tb_fifo_rd_ctrl;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int AE    = 2;
  localparam int MOD   = 2 * DEPTH;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_inc;
  logic [3:0] gray_w_ptr;
  logic [2:0] r_addr;
  logic [3:0] gray_r_ptr;
  logic       r_empty;
  logic       r_almost_empty;
  logic [3:0] r_level;
  logic       r_underflow;

  fifo_rd_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_inc(r_inc), .gray_w_ptr(gray_w_ptr),
    .r_addr(r_addr), .gray_r_ptr(gray_r_ptr), .r_empty(r_empty),
    .r_almost_empty(r_almost_empty), .r_level(r_level), .r_underflow(r_underflow)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    int addr;
    int gray;
    int empty;
    int ae;
    int level;
    int uf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: pointers as plain lap-counting integers.
  int rd = 0;
  int w_pipe[$];
  int wcnt = 0;

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int from_gray(int g);
    for (int b = 0; b < MOD; b++) if (to_gray(b) == g) return b;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each edge and queues the expected outputs.
  always @(posedge r_clk) begin
    exp_t e;
    int   vis;
    int   uf;
    uf = 0;
    if (r_rst) begin
      rd = 0;
      w_pipe.delete();
      for (int i = 0; i < SYNC; i++) w_pipe.push_back(0);
    end else begin
      vis = w_pipe[SYNC-1];
      uf  = (r_inc && vis == rd) ? 1 : 0;
      if (r_inc && vis != rd) rd = (rd + 1) % MOD;
      w_pipe.push_front(from_gray(int'(gray_w_ptr)));
      void'(w_pipe.pop_back());
    end
    vis     = w_pipe[SYNC-1];
    e.addr  = rd % DEPTH;
    e.gray  = to_gray(rd);
    e.empty = (vis == rd) ? 1 : 0;
    e.level = (vis - rd + MOD) % MOD;
    e.ae    = (e.level <= AE) ? 1 : 0;
    e.uf    = uf;
    sb_q.push_back(e);
  end

  // Monitor: compares every presented output set against the queued expectation.
  always @(negedge r_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("r_addr", int'(r_addr), e.addr);
      chk("gray_r_ptr", int'(gray_r_ptr), e.gray);
      chk("r_empty", int'(r_empty), e.empty);
      chk("r_level", int'(r_level), e.level);
      chk("r_almost_empty", int'(r_almost_empty), e.ae);
      chk("r_underflow", int'(r_underflow), e.uf);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic set_w(int b);
    wcnt       = b % MOD;
    gray_w_ptr = 4'(to_gray(wcnt));
  endtask

  task automatic do_reset(int cycles);
    r_rst = 1'b1;
    r_inc = 1'b0;
    set_w(0);
    step(cycles);
    r_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) w_pipe.push_back(0);
    r_rst      = 1'b1;
    r_inc      = 1'b0;
    gray_w_ptr = 4'b0110;
    wcnt       = 4;

    // Reset with a stale nonzero write pointer on the bus
    step(2);
    chk("rst_empty", int'(r_empty), 1);
    chk("rst_level", int'(r_level), 0);
    chk("rst_gray", int'(gray_r_ptr), 0);
    chk("rst_addr", int'(r_addr), 0);
    r_rst = 1'b0;
    step(2);
    chk("post_rst_level", int'(r_level), 4);
    chk("post_rst_empty", int'(r_empty), 0);
    r_inc = 1'b1;
    step(6);
    r_inc = 1'b0;
    step(2);

    // Sync latency and almost-empty boundary
    do_reset(2);
    step(2);
    set_w(1);
    step();
    chk("sync_k_empty", int'(r_empty), 1);
    step();
    chk("sync_k1_empty", int'(r_empty), 0);
    chk("sync_k1_level", int'(r_level), 1);
    chk("sync_k1_ae", int'(r_almost_empty), 1);
    set_w(2);
    step();
    set_w(3);
    step(3);
    chk("ae_lvl3_level", int'(r_level), 3);
    chk("ae_lvl3_ae", int'(r_almost_empty), 0);
    r_inc = 1'b1;
    step();
    chk("ae_lvl2_level", int'(r_level), 2);
    chk("ae_lvl2_ae", int'(r_almost_empty), 1);
    step(2);
    chk("ae_drained_empty", int'(r_empty), 1);

    // Underflow: three requests on an empty FIFO
    for (int i = 0; i < 3; i++) begin
      step();
      chk("uf_pulse", int'(r_underflow), 1);
      chk("uf_addr_frozen", int'(r_addr), 3);
    end
    r_inc = 1'b0;
    step();
    chk("uf_cleared", int'(r_underflow), 0);

    // Drain across the pointer wrap
    do_reset(2);
    r_inc = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      set_w(i);
      step();
    end
    step(4);
    r_inc = 1'b0;
    step();
    chk("drain_gray", int'(gray_r_ptr), 4'b1010);
    chk("drain_empty", int'(r_empty), 1);
    chk("drain_level", int'(r_level), 0);
    chk("drain_addr", int'(r_addr), 4);

    // Reset in the middle of popping
    do_reset(1);
    for (int i = 1; i <= 7; i++) begin
      set_w(i);
      step();
    end
    step(2);
    r_inc = 1'b1;
    step(5);
    chk("mid_addr_before", int'(r_addr), 5);
    r_rst = 1'b1;
    set_w(0);
    step();
    r_rst = 1'b0;
    r_inc = 1'b0;
    chk("mid_rst_addr", int'(r_addr), 0);
    chk("mid_rst_gray", int'(gray_r_ptr), 0);
    chk("mid_rst_empty", int'(r_empty), 1);
    chk("mid_rst_uf", int'(r_underflow), 0);
    step(2);

    // Randomized traffic with legal single-step write pointer motion
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        r_rst = 1'b1;
        set_w(0);
      end else begin
        r_rst = 1'b0;
        if (((wcnt - rd + MOD) % MOD) < DEPTH && $urandom_range(0, 1) == 1)
          set_w(wcnt + 1);
      end
      r_inc = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      step();
    end
    r_rst = 1'b0;
    r_inc = 1'b0;
    step(3);
    @(negedge r_clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
